// File: rtl/moving_average_acc.sv
// Running-sum moving-average filter with run-time power-of-two window,
// optional block decimation and warm-up flag. Define MOVING_AVERAGE_ROUND_EN for round-half-up with saturation.
module moving_average_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_DEPTH = 4,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         din_valid,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [SEL_WIDTH-1:0]  win_sel,
  input  logic                         decim,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic                         win_full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_WIDTH + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;

  logic signed [DATA_WIDTH-1:0] r_hist [DEPTH];
  logic        [LOG2_DEPTH-1:0] r_ptr;
  logic        [CNT_W-1:0]      r_count;
  logic signed [SUM_W-1:0]      r_sum;
  logic        [LOG2_DEPTH-1:0] r_dcnt;
  logic        [SEL_WIDTH-1:0]  r_wsel;
  logic signed [DATA_WIDTH-1:0] r_dout;
  logic                         r_dout_valid;

  logic        [SEL_WIDTH-1:0]  w_wsel_new;
  logic                         w_win_chg;
  logic        [CNT_W-1:0]      w_n;
  logic        [LOG2_DEPTH-1:0] w_old_idx;
  logic signed [DATA_WIDTH-1:0] w_oldest;
  logic signed [SUM_W-1:0]      w_sum_next;
  logic signed [DATA_WIDTH-1:0] w_avg;
  logic                         w_dcnt_last;
  logic                         w_emit;
`ifdef MOVING_AVERAGE_ROUND_EN
  logic signed [SUM_W:0]        w_rnd_sum;
  logic signed [SUM_W:0]        w_rnd_shift;
  logic        [SUM_W:0]        w_rnd_bias;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_wsel_new = (win_sel > SEL_WIDTH'(LOG2_DEPTH)) ? SEL_WIDTH'(LOG2_DEPTH) : win_sel;
    w_win_chg  = (w_wsel_new != r_wsel);
    w_n        = CNT_W'(1) << r_wsel;
    // N mod depth truncates to 0 at full depth, so the oldest slot is the one about to be overwritten.
    w_old_idx  = r_ptr - w_n[LOG2_DEPTH-1:0];
    w_oldest   = '0;
    if (r_count >= w_n) w_oldest = r_hist[w_old_idx];
    w_sum_next = r_sum + $signed({{LOG2_DEPTH{din[DATA_WIDTH-1]}}, din})
                       - $signed({{LOG2_DEPTH{w_oldest[DATA_WIDTH-1]}}, w_oldest});
`ifdef MOVING_AVERAGE_ROUND_EN
    w_rnd_bias  = '0;
    if (r_wsel != '0) w_rnd_bias = (SUM_W+1)'(1) << (r_wsel - SEL_WIDTH'(1));
    w_rnd_sum   = $signed({w_sum_next[SUM_W-1], w_sum_next}) + $signed(w_rnd_bias);
    w_rnd_shift = w_rnd_sum >>> r_wsel;
    w_avg       = w_rnd_shift[DATA_WIDTH-1:0];
    // Out of range when the bits above the result sign disagree with it.
    if (w_rnd_shift[SUM_W:DATA_WIDTH-1] != {(SUM_W-DATA_WIDTH+2){w_rnd_shift[SUM_W]}})
      w_avg = w_rnd_shift[SUM_W] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    w_avg = DATA_WIDTH'(w_sum_next >>> r_wsel);
`endif
    w_dcnt_last = ({1'b0, r_dcnt} == (w_n - CNT_W'(1)));
    w_emit      = !decim || w_dcnt_last;
  end

  // NOTE: the history array is cleared on reset as well, so warm-up never reads stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
      r_ptr        <= '0;
      r_count      <= '0;
      r_sum        <= '0;
      r_dcnt       <= '0;
      r_wsel       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (enable) begin
        if (clear || w_win_chg) begin
          r_ptr   <= '0;
          r_count <= '0;
          r_sum   <= '0;
          r_dcnt  <= '0;
          r_wsel  <= w_wsel_new;
        end else if (din_valid) begin
          r_hist[r_ptr] <= din;
          r_ptr         <= r_ptr + LOG2_DEPTH'(1);
          if (r_count != CNT_W'(DEPTH)) r_count <= r_count + CNT_W'(1);
          r_sum <= w_sum_next;
          if (decim) r_dcnt <= w_dcnt_last ? '0 : r_dcnt + LOG2_DEPTH'(1);
          else       r_dcnt <= '0;
          if (w_emit) begin
            r_dout       <= w_avg;
            r_dout_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign win_full   = (r_count >= w_n);

endmodule

// File: tb/tb_moving_average_acc.sv
// Self-checking bench for moving_average_acc: directed vector table plus a
// window-sum reference model feeding an output scoreboard.
module tb_moving_average_acc;

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               clear;
  logic               din_valid;
  logic signed [15:0] din;
  logic        [2:0]  win_sel;
  logic               decim;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               win_full;

  moving_average_acc #(.DATA_WIDTH(16), .LOG2_DEPTH(4), .SEL_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .din_valid(din_valid), .din(din), .win_sel(win_sel), .decim(decim),
    .dout(dout), .dout_valid(dout_valid), .win_full(win_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    bit          clr;
    bit          dv;
    int          d;
    int          ws;
    bit          dec;
    int          exp_dout;
    bit          exp_valid;
    bit          exp_full;
  } vec_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     m_samples[$];
  int     m_wsel;
  int     m_dcnt;
  longint m_dout;
  longint sb_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Floor division by 2^k, optionally with round-half-up and saturation.
  function automatic longint model_avg(input longint s, input int k);
    longint den, q;
    den = longint'(1) << k;
    if (ROUND && k > 0) s = s + den / 2;
    q = s / den;
    if ((s % den) != 0 && s < 0) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic drive(input bit en, input bit clr, input bit dv, input int d,
                       input int ws, input bit dec);
    bit     exp_v;
    int     eff, n, idx;
    longint s;
    enable = en; clear = clr; din_valid = dv; din = 16'(d); win_sel = 3'(ws); decim = dec;
    eff   = (ws > 4) ? 4 : ws;
    exp_v = 1'b0;
    if (en) begin
      if (clr || eff != m_wsel) begin
        m_samples.delete();
        m_dcnt = 0;
        m_wsel = eff;
      end else if (dv) begin
        m_samples.push_back(int'($signed(16'(d))));
        if (m_samples.size() > 16) void'(m_samples.pop_front());
        n = 1 << m_wsel;
        s = 0;
        for (int i = 0; i < n; i++) begin
          idx = m_samples.size() - 1 - i;
          if (idx >= 0) s += m_samples[idx];
        end
        if (dec) begin
          m_dcnt++;
          if (m_dcnt == n) begin m_dcnt = 0; exp_v = 1'b1; end
        end else begin
          m_dcnt = 0;
          exp_v  = 1'b1;
        end
        if (exp_v) begin
          m_dout = model_avg(s, m_wsel);
          sb_q.push_back(m_dout);
        end
      end
    end
    @(posedge clk); #1;
    check("dout_valid", dout_valid, exp_v);
    if (dout_valid) begin
      if (sb_q.size() == 0) check("sb_empty_pop", 1, 0);
      else                  check("dout_sb", dout, sb_q.pop_front());
    end else begin
      sb_q.delete();
      check("dout_hold", dout, m_dout);
    end
    check("win_full", win_full, m_samples.size() >= (1 << m_wsel));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; din_valid = 1'b1; din = 16'sd123;
    win_sel = 3'd2; decim = 1'b0;
    @(posedge clk); #1;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_full", win_full, 0);
    m_samples.delete(); m_wsel = 0; m_dcnt = 0; m_dout = 0; sb_q.delete();
    rst_n = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1, 0, 0,   0, 2, 0,  0, 0, 0});
    vecs.push_back('{1, 0, 1,   4, 2, 0,  1, 1, 0});
    vecs.push_back('{1, 0, 1,   8, 2, 0,  3, 1, 0});
    vecs.push_back('{1, 0, 1,  12, 2, 0,  6, 1, 0});
    vecs.push_back('{1, 0, 1,  16, 2, 0, 10, 1, 1});
    vecs.push_back('{1, 0, 1,  20, 2, 0, 14, 1, 1});
    vecs.push_back('{1, 0, 1,  99, 1, 1, 14, 0, 0});
    vecs.push_back('{1, 0, 1,   2, 1, 1, 14, 0, 0});
    vecs.push_back('{1, 0, 1,   4, 1, 1,  3, 1, 1});
    vecs.push_back('{1, 0, 1,   6, 1, 1,  3, 0, 1});
    vecs.push_back('{1, 0, 1,   8, 1, 1,  7, 1, 1});
    vecs.push_back('{1, 1, 1, 100, 1, 1,  7, 0, 0});
    vecs.push_back('{0, 0, 1,  50, 1, 1,  7, 0, 0});
    vecs.push_back('{0, 0, 1,  50, 1, 1,  7, 0, 0});
    vecs.push_back('{0, 0, 1,  50, 1, 1,  7, 0, 0});
    vecs.push_back('{1, 0, 1,   1, 1, 0, ROUND ? 1 : 0, 1, 0});
    vecs.push_back('{1, 0, 1,   2, 1, 0, ROUND ? 2 : 1, 1, 1});

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].dv, vecs[i].d, vecs[i].ws, vecs[i].dec);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_valid", i), dout_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_full", i), win_full, vecs[i].exp_full);
    end

    // Full-depth window of most-negative samples, pointer wraps twice.
    drive(1, 0, 0, 0, 4, 0);
    for (int i = 0; i < 40; i++) drive(1, 0, 1, -32768, 4, 0);
    check("neg_settle", dout, -32768);
    check("neg_full", win_full, 1);

    // Window change mid-stream drops the offered sample and restarts warm-up.
    drive(1, 0, 0, 0, 2, 0);
    for (int i = 0; i < 6; i++) drive(1, 0, 1, 100 * i - 250, 2, 0);
    drive(1, 0, 1, 777, 3, 0);
    check("wchg_valid", dout_valid, 0);
    check("wchg_full", win_full, 0);
    for (int i = 0; i < 7; i++) drive(1, 0, 1, 31 * i + 5, 3, 0);
    check("warm7_full", win_full, 0);
    drive(1, 0, 1, 1000, 3, 0);
    check("warm8_full", win_full, 1);

    // Reset mid-operation, then first accept behaves as count=0 with N=1.
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 500 + i, 3, 0);
    do_reset();
    drive(1, 0, 1, -1234, 0, 0);
    check("post_rst_dout", dout, ROUND ? -1234 : -1234);
    check("post_rst_full", win_full, 1);

    // Randomised stream against the reference model.
    begin
      bit en, clr, dv, dec;
      int ws;
      ws = 0; dec = 1'b0;
      for (int i = 0; i < 400; i++) begin
        en  = ($urandom_range(0, 9) != 0);
        clr = ($urandom_range(0, 29) == 0);
        dv  = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 24) == 0) ws  = $urandom_range(0, 7);
        if ($urandom_range(0, 19) == 0) dec = ~dec;
        drive(en, clr, dv, int'($signed(16'($urandom_range(0, 65535)))), ws, dec);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
